// File: rtl/flappy_game_ctrl.sv
// Flappy-bird game-state engine: per-frame bird/pipe update, collision detection and
// scoring, paced by the renderer's vsync and driven by a raw flap push-button.
module flappy_game_ctrl #(
    parameter int BIRD_X     = 100,
    parameter int BIRD_W     = 16,
    parameter int BIRD_H     = 16,
    parameter int BIRD_Y0    = 240,
    parameter int FLOOR      = 440,
    parameter int PIPE_W     = 40,
    parameter int PIPE_START = 500,
    parameter int PIPE_SPEED = 2,
    parameter int GAP_TOP    = 180,
    parameter int GAP_BOT    = 300,
    parameter int GRAVITY    = 1,
    parameter int FLAP_V     = 8,
    parameter int MAX_V      = 10
) (
    input  logic       dclk,
    input  logic       clr,
    input  logic       vsync,
    input  logic       flap,
    output logic [9:0] bird_coord,
    output logic [8:0] pipe_pos,
    output logic [7:0] score,
    output logic       playing,
    output logic       game_over
);

    localparam logic [9:0]        BIRD_Y0_V    = 10'(BIRD_Y0);
    localparam logic [9:0]        FLOOR_V      = 10'(FLOOR);
    localparam logic signed [10:0] FLOOR_S     = 11'(FLOOR);
    localparam logic [8:0]        PIPE_START_V = 9'(PIPE_START);
    localparam logic [8:0]        PIPE_SPEED_V = 9'(PIPE_SPEED);
    localparam logic [9:0]        BIRD_LEFT    = 10'(BIRD_X);
    localparam logic [9:0]        BIRD_RIGHT   = 10'(BIRD_X + BIRD_W);
    localparam logic [9:0]        PIPE_W_V     = 10'(PIPE_W);
    localparam logic [9:0]        BIRD_H_V     = 10'(BIRD_H);
    localparam logic [9:0]        GAP_TOP_V    = 10'(GAP_TOP);
    localparam logic [9:0]        GAP_BOT_V    = 10'(GAP_BOT);
    localparam logic signed [6:0] GRAVITY_V    = 7'(GRAVITY);
    localparam logic signed [6:0] MAX_V_V      = 7'(MAX_V);
    localparam logic signed [5:0] FLAP_VEL     = 6'(-FLAP_V);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        DEAD
    } state_t;

    state_t state, state_n;

    logic vsync_s1, vsync_s2, vsync_d;
    logic flap_s1, flap_s2, flap_d;
    logic frame_tick, flap_edge;

    logic signed [5:0] velocity, velocity_n;
    logic              flap_pend, flap_pend_n;
    logic [9:0]        bird_n;
    logic [8:0]        pipe_n;
    logic [7:0]        score_n;

    logic signed [6:0]  vel_grav;
    logic signed [5:0]  vel_step, vel_calc, vel_keep;
    logic signed [10:0] pos_calc;
    logic [9:0]         bird_calc, pipe_ext;
    logic [8:0]         pipe_calc;
    logic               wrap, hit_floor, overlap_h, hit_v, crash;

    assign frame_tick = vsync_d & ~vsync_s2;
    assign flap_edge  = flap_s2 & ~flap_d;

    // Candidate next-frame values; only committed by the FSM on a PLAY frame tick.
    always_comb begin
        vel_grav = {velocity[5], velocity} + GRAVITY_V;
        if (vel_grav > MAX_V_V) vel_step = MAX_V_V[5:0];
        else                    vel_step = vel_grav[5:0];
        vel_calc = (flap_pend || flap_edge) ? FLAP_VEL : vel_step;

        pos_calc  = $signed({1'b0, bird_coord}) + $signed({{5{vel_calc[5]}}, vel_calc});
        bird_calc = pos_calc[9:0];
        vel_keep  = vel_calc;
        hit_floor = 1'b0;
        if (pos_calc[10]) begin
            bird_calc = '0;
            vel_keep  = '0;
        end else if (pos_calc >= FLOOR_S) begin
            bird_calc = FLOOR_V;
            hit_floor = 1'b1;
        end

        wrap      = pipe_pos < PIPE_SPEED_V;
        pipe_calc = wrap ? PIPE_START_V : pipe_pos - PIPE_SPEED_V;
        pipe_ext  = {1'b0, pipe_calc};

        overlap_h = (pipe_ext < BIRD_RIGHT) && ((pipe_ext + PIPE_W_V) > BIRD_LEFT);
        hit_v     = (bird_calc < GAP_TOP_V) || ((bird_calc + BIRD_H_V) > GAP_BOT_V);
        crash     = hit_floor || (overlap_h && hit_v);
    end

    always_comb begin
        state_n     = state;
        bird_n      = bird_coord;
        pipe_n      = pipe_pos;
        score_n     = score;
        velocity_n  = velocity;
        flap_pend_n = flap_pend;

        unique case (state)
            IDLE: begin
                flap_pend_n = 1'b0;
                if (flap_edge) begin
                    state_n    = PLAY;
                    velocity_n = '0;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    flap_pend_n = 1'b0;
                    bird_n      = bird_calc;
                    pipe_n      = pipe_calc;
                    velocity_n  = vel_keep;
                    if (crash)
                        state_n = DEAD;
                    else if (wrap && score != 8'hFF)
                        score_n = score + 8'd1;
                end else if (flap_edge) begin
                    flap_pend_n = 1'b1;
                end
            end
            DEAD: begin
                flap_pend_n = 1'b0;
                if (flap_edge) begin
                    state_n    = IDLE;
                    bird_n     = BIRD_Y0_V;
                    pipe_n     = PIPE_START_V;
                    score_n    = '0;
                    velocity_n = '0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge dclk or negedge clr) begin
        if (!clr) begin
            vsync_s1   <= 1'b1;
            vsync_s2   <= 1'b1;
            vsync_d    <= 1'b1;
            flap_s1    <= 1'b0;
            flap_s2    <= 1'b0;
            flap_d     <= 1'b0;
            state      <= IDLE;
            bird_coord <= BIRD_Y0_V;
            pipe_pos   <= PIPE_START_V;
            score      <= '0;
            velocity   <= '0;
            flap_pend  <= 1'b0;
            playing    <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            vsync_s1   <= vsync;
            vsync_s2   <= vsync_s1;
            vsync_d    <= vsync_s2;
            flap_s1    <= flap;
            flap_s2    <= flap_s1;
            flap_d     <= flap_s2;
            state      <= state_n;
            bird_coord <= bird_n;
            pipe_pos   <= pipe_n;
            score      <= score_n;
            velocity   <= velocity_n;
            flap_pend  <= flap_pend_n;
            playing    <= (state_n == PLAY);
            game_over  <= (state_n == DEAD);
        end
    end

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Self-checking bench for flappy_game_ctrl: directed game scenarios plus randomized play,
// compared against a frame-level game model for a default and a short-pipe instance.
`timescale 1ns/1ps
module tb_flappy_game_ctrl;

    logic dclk = 1'b0;
    logic clr, vsync, flap;
    logic [9:0] bird0, bird1;
    logic [8:0] pipe0, pipe1;
    logic [7:0] score0, score1;
    logic play0, play1, over0, over1;

    int tests = 0;
    int fails = 0;

    int pstart [2] = '{500, 50};
    int m_state[2];  // 0 idle, 1 play, 2 dead
    int m_bird [2];
    int m_pipe [2];
    int m_score[2];
    int m_vel  [2];
    int m_pend [2];

    always #5 dclk = ~dclk;

    flappy_game_ctrl dut0 (
        .dclk(dclk), .clr(clr), .vsync(vsync), .flap(flap),
        .bird_coord(bird0), .pipe_pos(pipe0), .score(score0),
        .playing(play0), .game_over(over0)
    );

    flappy_game_ctrl #(.PIPE_START(50)) dut1 (
        .dclk(dclk), .clr(clr), .vsync(vsync), .flap(flap),
        .bird_coord(bird1), .pipe_pos(pipe1), .score(score1),
        .playing(play1), .game_over(over1)
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_state[i] = 0; m_bird[i] = 240; m_pipe[i] = pstart[i];
            m_score[i] = 0; m_vel[i] = 0;    m_pend[i] = 0;
        end
    endtask

    task automatic model_flap();
        for (int i = 0; i < 2; i++) begin
            if (m_state[i] == 0) begin
                m_state[i] = 1; m_vel[i] = 0; m_pend[i] = 0;
            end else if (m_state[i] == 1) begin
                m_pend[i] = 1;
            end else begin
                m_state[i] = 0; m_bird[i] = 240; m_pipe[i] = pstart[i];
                m_score[i] = 0; m_vel[i] = 0;    m_pend[i] = 0;
            end
        end
    endtask

    task automatic model_tick();
        int v, p;
        bit dead, wrapped;
        for (int i = 0; i < 2; i++) begin
            if (m_state[i] != 1) continue;
            v = m_pend[i] ? -8 : ((m_vel[i] + 1 > 10) ? 10 : m_vel[i] + 1);
            m_pend[i] = 0;
            p = m_bird[i] + v;
            dead = 0;
            if (p < 0)          begin m_bird[i] = 0;   m_vel[i] = 0; end
            else if (p >= 440)  begin m_bird[i] = 440; m_vel[i] = v; dead = 1; end
            else                begin m_bird[i] = p;   m_vel[i] = v; end
            wrapped = m_pipe[i] < 2;
            m_pipe[i] = wrapped ? pstart[i] : m_pipe[i] - 2;
            if ((m_pipe[i] < 116) && (m_pipe[i] + 40 > 100) &&
                ((m_bird[i] < 180) || (m_bird[i] + 16 > 300)))
                dead = 1;
            if (dead) m_state[i] = 2;
            else if (wrapped && m_score[i] < 255) m_score[i]++;
        end
    endtask

    // Flap edge and frame tick arriving on the same clock.
    task automatic model_sim();
        for (int i = 0; i < 2; i++) begin
            if (m_state[i] == 1) m_pend[i] = 1;
        end
        for (int i = 0; i < 2; i++) begin
            if (m_state[i] != 1) begin
                m_state[i] = (m_state[i] == 0) ? 1 : 0;
                m_vel[i] = 0; m_pend[i] = 0;
                if (m_state[i] == 0) begin
                    m_bird[i] = 240; m_pipe[i] = pstart[i]; m_score[i] = 0;
                end
            end
        end
        model_tick_playing_only();
    endtask

    // Ticks only the instances that were already playing before the simultaneous flap.
    int was_play[2];
    task automatic model_tick_playing_only();
        int save[2];
        for (int i = 0; i < 2; i++) begin
            save[i] = m_state[i];
            if (!was_play[i]) m_state[i] = 3;
        end
        model_tick();
        for (int i = 0; i < 2; i++) begin
            if (!was_play[i]) m_state[i] = save[i];
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " bird0"},  32'(bird0),  32'(m_bird[0]));
        chk({tag, " pipe0"},  32'(pipe0),  32'(m_pipe[0]));
        chk({tag, " score0"}, 32'(score0), 32'(m_score[0]));
        chk({tag, " play0"},  32'(play0),  32'(m_state[0] == 1));
        chk({tag, " over0"},  32'(over0),  32'(m_state[0] == 2));
        chk({tag, " bird1"},  32'(bird1),  32'(m_bird[1]));
        chk({tag, " pipe1"},  32'(pipe1),  32'(m_pipe[1]));
        chk({tag, " score1"}, 32'(score1), 32'(m_score[1]));
        chk({tag, " play1"},  32'(play1),  32'(m_state[1] == 1));
        chk({tag, " over1"},  32'(over1),  32'(m_state[1] == 2));
    endtask

    task automatic press();
        @(negedge dclk) flap = 1'b1;
        repeat (3) @(negedge dclk);
        flap = 1'b0;
        repeat (3) @(negedge dclk);
        model_flap();
    endtask

    task automatic tick(input bit with_flap);
        @(negedge dclk);
        vsync = 1'b0;
        if (with_flap) flap = 1'b1;
        repeat (4) @(negedge dclk);
        vsync = 1'b1;
        flap  = 1'b0;
        repeat (4) @(negedge dclk);
        if (with_flap) begin
            for (int i = 0; i < 2; i++) was_play[i] = (m_state[i] == 1);
            model_sim();
        end else begin
            model_tick();
        end
    endtask

    task automatic hard_reset();
        @(negedge dclk) clr = 1'b0;
        @(negedge dclk) clr = 1'b1;
        model_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, n;
        clr = 1'b0; vsync = 1'b1; flap = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge dclk) clr = 1'b1;

        for (int k = 0; k < 3; k++) begin
            tick(1'b0);
            check_all("idle_tick");
        end

        press();
        chk("start play0", 32'(play0), 32'd1);
        tick(1'b0); check_all("fall1"); chk("fall1 bird", 32'(bird0), 32'd241);
        tick(1'b0); check_all("fall2"); chk("fall2 bird", 32'(bird0), 32'd243);
        tick(1'b0); check_all("fall3"); chk("fall3 bird", 32'(bird0), 32'd246);
        chk("fall3 pipe", 32'(pipe0), 32'd494);
        press();
        tick(1'b0); check_all("flap4"); chk("flap4 bird", 32'(bird0), 32'd238);

        hard_reset();
        press();
        for (int k = 1; k <= 27; k++) begin
            tick(1'b0);
            check_all("drop");
            if (k == 24) chk("drop24 bird", 32'(bird0), 32'd435);
            if (k >= 25) begin
                chk("floor bird", 32'(bird0), 32'd440);
                chk("floor pipe", 32'(pipe0), 32'd450);
                chk("floor over", 32'(over0), 32'd1);
            end
        end

        hard_reset();
        press();
        for (int k = 1; k <= 193; k++) begin
            press();
            tick(1'b0);
            check_all("climb");
            if (k == 25) chk("wrap25 pipe1", 32'(pipe1), 32'd0);
            if (k == 26) begin
                chk("wrap26 pipe1",  32'(pipe1),  32'd50);
                chk("wrap26 score1", 32'(score1), 32'd1);
                chk("wrap26 over1",  32'(over1),  32'd0);
            end
        end
        chk("pipe hit pipe",  32'(pipe0),  32'd114);
        chk("pipe hit over",  32'(over0),  32'd1);
        chk("pipe hit score", 32'(score0), 32'd0);
        chk("pipe hit bird",  32'(bird0),  32'd0);
        press();
        check_all("restart");
        chk("restart pipe", 32'(pipe0), 32'd500);

        hard_reset();
        for (int k = 0; k < 250; k++) begin
            r = $urandom_range(0, 9);
            if (r >= 4 && r <= 6) begin
                n = $urandom_range(1, 3);
                for (int j = 0; j < n; j++) press();
                tick(1'b0);
            end else if (r == 7) begin
                tick(1'b1);
            end else if (r == 8) begin
                press();
                tick(1'b1);
            end else if (r == 9) begin
                press();
            end else begin
                tick(1'b0);
            end
            check_all("rand");
        end

        hard_reset();
        press();
        for (int k = 0; k < 5; k++) tick(1'b0);
        check_all("pre_clr");
        @(posedge dclk);
        #3 clr = 1'b0;
        model_reset();
        #1;
        check_all("async_clr");
        @(negedge dclk) clr = 1'b1;
        press();
        tick(1'b0);
        check_all("fresh");
        chk("fresh bird", 32'(bird0), 32'd241);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
